deserializer_align: RTL and testbench

// - Receive end of the serial link: rebuilds 8-bit words from the MSB-first bit stream the serializer emits, one bit per posedge clk.
// - Finds word boundaries by locking onto a control comma (COMMA with dk_in=1), then outputs each word with its data/control (DK) flag.
// - Sits between the serial lane and the parallel receive path; its outputs feed the downstream word consumer.

---
 rtl/deserializer_align_pkg.sv | 14 +
 rtl/deserializer_align_fsm.sv | 87 ++++++++
 rtl/deserializer_align.sv | 84 ++++++++
 tb/tb_deserializer_align.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/deserializer_align_pkg.sv
// Shared definitions for the serial receive lane: alignment state encoding and
// default word geometry.
package deserializer_align_pkg;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_LOCKED  = 2'd2
    } align_state_e;

    localparam int         DEF_WIDTH = 8;
    localparam logic [7:0] DEF_COMMA = 8'hBC;

endpackage

// File: rtl/deserializer_align_fsm.sv
// Word-alignment state machine: qualifies commas into lock and tracks
// consecutive illegal control words to drop lock.
module align_fsm
    import deserializer_align_pkg::*;
#(
    parameter int LOCK_COUNT = 4,
    parameter int ERR_LIMIT  = 3
) (
    input  logic         clk,
    input  logic         reset_L,
    input  logic         comma_i,
    input  logic         illegal_i,
    input  logic         boundary_i,
    output align_state_e state_o,
    output logic         locked_o
);

    localparam int CW = $clog2(LOCK_COUNT + 1);
    localparam int EW = $clog2(ERR_LIMIT + 1);
    localparam logic [CW-1:0] LOCK_MAX = CW'(LOCK_COUNT);
    localparam logic [EW-1:0] ERR_MAX  = EW'(ERR_LIMIT);

    align_state_e  state_q;
    logic [CW-1:0] comma_cnt_q;
    logic [EW-1:0] err_cnt_q;
    logic          locked_q;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q     <= ST_SEARCH;
            comma_cnt_q <= '0;
            err_cnt_q   <= '0;
            locked_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_SEARCH: begin
                    if (comma_i) begin
                        comma_cnt_q <= CW'(1);
                        if (LOCK_COUNT == 1) begin
                            state_q  <= ST_LOCKED;
                            locked_q <= 1'b1;
                        end else begin
                            state_q <= ST_CONFIRM;
                        end
                    end
                end
                ST_CONFIRM: begin
                    if (boundary_i) begin
                        if (!comma_i) begin
                            state_q     <= ST_SEARCH;
                            comma_cnt_q <= '0;
                        end else if (comma_cnt_q >= LOCK_MAX - 1'b1) begin
                            state_q     <= ST_LOCKED;
                            locked_q    <= 1'b1;
                            comma_cnt_q <= LOCK_MAX;
                        end else begin
                            comma_cnt_q <= comma_cnt_q + 1'b1;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (boundary_i) begin
                        if (!illegal_i) begin
                            err_cnt_q <= '0;
                        end else if (err_cnt_q >= ERR_MAX - 1'b1) begin
                            // Counters restart so the next lock attempt begins clean.
                            state_q     <= ST_SEARCH;
                            locked_q    <= 1'b0;
                            err_cnt_q   <= '0;
                            comma_cnt_q <= '0;
                        end else begin
                            err_cnt_q <= err_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q  <= ST_SEARCH;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

    assign state_o  = state_q;
    assign locked_o = locked_q;

endmodule

// File: rtl/deserializer_align.sv
// Serial-to-parallel receiver: shifts in MSB-first bits, aligns on a control
// comma and emits one word with its DK flag per WIDTH clocks once locked.
module deserializer_align
    import deserializer_align_pkg::*;
#(
    parameter int               WIDTH      = DEF_WIDTH,
    parameter logic [WIDTH-1:0] COMMA      = WIDTH'(DEF_COMMA),
    parameter int               LOCK_COUNT = 4,
    parameter int               ERR_LIMIT  = 3
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             in,
    input  logic             dk_in,
    output logic [WIDTH-1:0] data_out,
    output logic             dk_out,
    output logic             valid_out,
    output logic             locked
);

    localparam int BW = $clog2(WIDTH);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    logic [WIDTH-2:0] sr_q;
    logic [BW-1:0]    bit_cnt_q;
    logic [WIDTH-1:0] data_out_q;
    logic             dk_out_q;
    logic             valid_out_q;

    logic [WIDTH-1:0] w;
    logic             comma;
    logic             illegal;
    logic             boundary;
    align_state_e     state;

    // w is the word that ends on the bit arriving this cycle.
    assign w        = {sr_q, in};
    assign comma    = dk_in && (w == COMMA);
    assign illegal  = dk_in && (w != COMMA);
    assign boundary = (state != ST_SEARCH) && (bit_cnt_q == BIT_LAST);

    align_fsm #(
        .LOCK_COUNT (LOCK_COUNT),
        .ERR_LIMIT  (ERR_LIMIT)
    ) u_fsm (
        .clk        (clk),
        .reset_L    (reset_L),
        .comma_i    (comma),
        .illegal_i  (illegal),
        .boundary_i (boundary),
        .state_o    (state),
        .locked_o   (locked)
    );

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            sr_q        <= '0;
            bit_cnt_q   <= '0;
            data_out_q  <= '0;
            dk_out_q    <= 1'b0;
            valid_out_q <= 1'b0;
        end else begin
            sr_q        <= w[WIDTH-2:0];
            valid_out_q <= 1'b0;
            if (state == ST_SEARCH) begin
                bit_cnt_q <= '0;
            end else if (bit_cnt_q == BIT_LAST) begin
                bit_cnt_q <= '0;
            end else begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
            end
            if (boundary && (state == ST_LOCKED)) begin
                data_out_q  <= w;
                dk_out_q    <= dk_in;
                valid_out_q <= 1'b1;
            end
        end
    end

    assign data_out  = data_out_q;
    assign dk_out    = dk_out_q;
    assign valid_out = valid_out_q;

endmodule

// File: tb/tb_deserializer_align.sv
// Randomised scoreboard bench for deserializer_align against a word-level
// behavioural model of the alignment rules.
module tb_deserializer_align;

    localparam logic [7:0] K_COMMA = 8'hBC;

    logic       clk = 1'b0;
    logic       reset_L = 1'b0;
    logic       in_bit = 1'b0;
    logic       dk_in = 1'b0;
    logic [7:0] data_out;
    logic       dk_out;
    logic       valid_out;
    logic       locked;

    always #5 clk = ~clk;

    deserializer_align dut (
        .clk       (clk),
        .reset_L   (reset_L),
        .in        (in_bit),
        .dk_in     (dk_in),
        .data_out  (data_out),
        .dk_out    (dk_out),
        .valid_out (valid_out),
        .locked    (locked)
    );

    typedef struct {
        int         cyc;
        bit         v;
        bit         lk;
        logic [7:0] d;
        bit         k;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_valid = 0;
    bit   rst_active = 1'b1;

    // Reference model: mode 0 hunting, 1 counting commas, 2 locked.
    int m_mode, m_bits, m_commas, m_errs, m_win;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_mode = 0; m_bits = 0; m_commas = 0; m_errs = 0; m_win = 0;
    endfunction

    function automatic void model_step(input bit b, input bit k);
        exp_t e;
        bit   is_comma;
        m_win    = ((m_win << 1) | int'(b)) & 255;
        is_comma = k && (m_win == int'(K_COMMA));
        e.cyc = cyc + 1; e.v = 1'b0; e.d = 8'h00; e.k = 1'b0;
        if (m_mode == 0) begin
            if (is_comma) begin
                m_mode = 1; m_commas = 1; m_bits = 0;
            end
        end else begin
            m_bits = m_bits + 1;
            if (m_bits == 8) begin
                m_bits = 0;
                if (m_mode == 1) begin
                    if (is_comma) begin
                        m_commas++;
                        if (m_commas >= 4) m_mode = 2;
                    end else begin
                        m_mode = 0; m_commas = 0;
                    end
                end else begin
                    e.v = 1'b1; e.d = 8'(m_win); e.k = k;
                    if (k && (m_win != int'(K_COMMA))) begin
                        m_errs++;
                        if (m_errs >= 3) begin
                            m_mode = 0; m_errs = 0; m_commas = 0;
                        end
                    end else begin
                        m_errs = 0;
                    end
                end
            end
        end
        e.lk = (m_mode == 2);
        q.push_back(e);
    endfunction

    task automatic send_bit(input bit b, input bit k);
        in_bit = b;
        dk_in  = k;
        model_step(b, k);
        @(posedge clk);
        #2;
    endtask

    task automatic send_word(input logic [7:0] v, input bit k);
        for (int i = 7; i >= 0; i--) send_bit(v[i], k);
    endtask

    // DK toggles randomly on every bit except the LSB, where it is sampled.
    task automatic send_word_noisy_dk(input logic [7:0] v, input bit k);
        for (int i = 7; i >= 1; i--) send_bit(v[i], 1'($urandom_range(0, 1)));
        send_bit(v[0], k);
    endtask

    task automatic send_commas(input int n);
        for (int i = 0; i < n; i++) send_word(K_COMMA, 1'b1);
    endtask

    task automatic do_reset(input int hold);
        reset_L    = 1'b0;
        rst_active = 1'b1;
        q.delete();
        model_reset();
        for (int i = 0; i < hold; i++) begin
            in_bit = 1'($urandom_range(0, 1));
            dk_in  = 1'($urandom_range(0, 1));
            @(posedge clk);
            #2;
        end
        reset_L    = 1'b1;
        rst_active = 1'b0;
    endtask

    // Monitor: compares every presented output against the queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_active) begin
            chk("rst_data", 32'(data_out), 32'h0);
            chk("rst_dk", 32'(dk_out), 32'h0);
            chk("rst_valid", 32'(valid_out), 32'h0);
            chk("rst_locked", 32'(locked), 32'h0);
        end else begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
                chk("stale_expect", 32'(q[0].cyc), 32'(cyc));
                e = q.pop_front();
            end
            if (q.size() > 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
                chk("valid", 32'(valid_out), 32'(e.v));
                chk("locked", 32'(locked), 32'(e.lk));
                if (e.v) begin
                    chk("data", 32'(data_out), 32'(e.d));
                    chk("dk", 32'(dk_out), 32'(e.k));
                end
            end else begin
                chk("idle_valid", 32'(valid_out), 32'h0);
            end
        end
    end

    always @(negedge clk) if (!rst_active && valid_out) n_valid++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "timeout");
    end

    initial begin
        int v0;
        model_reset();
        @(posedge clk);
        #2;
        do_reset(6);

        // Idle random bits with dk=0 never lock.
        for (int i = 0; i < 20; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);

        // Lock at an arbitrary bit offset, then first data word.
        for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
        send_commas(4);
        send_word(8'h5A, 1'b0);
        for (int i = 0; i < 6; i++) send_word(8'($urandom), 1'b0);

        // Loss of lock after three illegal control words.
        for (int i = 0; i < 3; i++) send_word(8'h33, 1'b1);
        send_word(8'h00, 1'b0);

        // Relock; two illegal words then a legal one keeps lock.
        send_commas(4);
        send_word(8'h33, 1'b1);
        send_word(8'h33, 1'b1);
        send_word(8'h11, 1'b0);
        send_word(8'h33, 1'b1);
        send_word(8'h33, 1'b1);
        send_word(8'h22, 1'b0);
        for (int i = 0; i < 4; i++) send_word_noisy_dk(8'($urandom), 1'b0);

        // Drop lock, then a false lock attempt.
        for (int i = 0; i < 3; i++) send_word(8'h33, 1'b1);
        send_bit(1'b0, 1'b0);
        send_commas(2);
        send_word(8'h00, 1'b0);
        for (int i = 0; i < 4; i++) send_word(8'h00, 1'b0);

        // Throughput: full byte ramp while locked.
        send_commas(4);
        v0 = n_valid;
        for (int i = 0; i < 256; i++) send_word(8'(i), 1'b0);
        @(negedge clk);
        #1;
        chk("ramp_count", 32'(n_valid - v0), 32'd256);

        // Mid-word reset, then three commas are not enough to relock.
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        do_reset(3);
        send_commas(3);
        send_word(8'h5A, 1'b0);
        send_commas(4);
        for (int i = 0; i < 4; i++) send_word(8'($urandom), 1'b0);

        // Random traffic with commas, illegal words and bit slips.
        for (int i = 0; i < 300; i++) begin
            int r;
            logic [7:0] d;
            r = $urandom_range(0, 19);
            if (r < 3) begin
                send_word(K_COMMA, 1'b1);
            end else if (r < 5) begin
                d = 8'($urandom);
                if (d == K_COMMA) d = 8'h33;
                send_word(d, 1'b1);
            end else if (r == 5) begin
                for (int j = 0; j < $urandom_range(1, 3); j++)
                    send_bit(1'($urandom_range(0, 1)), 1'b0);
            end else begin
                send_word(8'($urandom), 1'b0);
            end
        end

        // Loopback-style framed stream: comma preamble then mixed words.
        send_commas(5);
        for (int i = 0; i < 40; i++) begin
            if (i % 7 == 3) send_word(K_COMMA, 1'b1);
            else send_word(8'($urandom), 1'b0);
        end

        @(negedge clk);
        #1;
        chk("queue_drain", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
